tdm_demux_1to4: RTL and testbench

Four-channel time-division demultiplexer. It receives the serial TDM stream built by the lab's 4:1 slot-select mux, recovers frame alignment from a frame-sync marker, and writes each slot's sample into its channel lane. A complete frame is presented on a registered parallel output with a one-cycle valid strobe. Misalignment is detected, counted and recovered without software involvement.

---
 rtl/tdm_demux_1to4_pkg.sv | 19 +
 rtl/tdm_slot_ctr.sv | 24 ++
 rtl/tdm_demux_1to4.sv | 100 ++++++++++
 tb/tb_tdm_demux_1to4.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_1to4_pkg.sv
// Shared types and constants for the 1:4 TDM demultiplexer.
// Frame alignment states and slot geometry are kept here so the counter and top agree.
package tdm_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam int NUM_SLOTS     = 4;
   localparam int SLOT_W        = 2;
   localparam int ERR_W_DEFAULT = 8;

   // The last slot of a frame is the one whose sample completes the output word.
   function automatic logic is_last_slot(input logic [SLOT_W-1:0] slot);
      return slot == SLOT_W'(NUM_SLOTS - 1);
   endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter for the TDM demux: clear wins over load-one, which wins over increment.
// The count doubles as the lane index for the next accepted sample.
module tdm_slot_ctr
   import tdm_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              load_one,
   input  logic              inc,
   output logic [SLOT_W-1:0] slot
);

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         slot <= '0;
      end else if (load_one) begin
         slot <= SLOT_W'(1);
      end else if (inc) begin
         slot <= slot + SLOT_W'(1);
      end
   end

endmodule

// File: rtl/tdm_demux_1to4.sv
// Four-channel TDM demultiplexer: recovers frame alignment from the sync marker,
// collects slots into a shadow word and publishes complete frames with a valid strobe.
module tdm_demux_1to4
   import tdm_pkg::*;
#(
   parameter int DW    = 1,
   parameter int ERR_W = ERR_W_DEFAULT
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic [DW-1:0]     d_in,
   input  logic              valid_in,
   input  logic              frame_sync_in,
   output logic [4*DW-1:0]   y_out,
   output logic              y_valid_out,
   output logic [1:0]        sel_out,
   output logic              locked_out,
   output logic              sync_err_out,
   output logic [ERR_W-1:0]  err_cnt_out
);

   state_t            state;
   logic [SLOT_W-1:0] slot;
   logic [4*DW-1:0]   shadow;
   logic              early_sync;
   logic              missing_sync;
   logic              accept;

   // Classify the current sample against the expected frame position.
   always_comb begin
      early_sync   = valid_in && (state == LOCKED) && frame_sync_in && (slot != '0);
      missing_sync = valid_in && (state == LOCKED) && !frame_sync_in && (slot == '0);
      accept       = valid_in && (state == LOCKED) && !early_sync && !missing_sync;
   end

   tdm_slot_ctr u_slot_ctr (
      .clk      (clk_in),
      .rst_n    (rst_n_in),
      .clear    (missing_sync),
      .load_one (valid_in && frame_sync_in),
      .inc      (accept),
      .slot     (slot)
   );

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state       <= HUNT;
         shadow      <= '0;
         y_out       <= '0;
         y_valid_out <= 1'b0;
      end else begin
         y_valid_out <= 1'b0;
         if (valid_in) begin
            case (state)
               HUNT: begin
                  if (frame_sync_in) begin
                     shadow <= {{(3*DW){1'b0}}, d_in};
                     state  <= LOCKED;
                  end
               end
               LOCKED: begin
                  if (early_sync) begin
                     // The partial frame is dropped; this sample starts a fresh one.
                     shadow <= {{(3*DW){1'b0}}, d_in};
                  end else if (missing_sync) begin
                     state <= HUNT;
                  end else begin
                     for (int k = 0; k < NUM_SLOTS; k++) begin
                        if (slot == SLOT_W'(k)) begin
                           shadow[k*DW +: DW] <= d_in;
                        end
                     end
                     if (is_last_slot(slot)) begin
                        y_out       <= {d_in, shadow[3*DW-1:0]};
                        y_valid_out <= 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

   // Saturating error counter; it only returns to zero through reset.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         sync_err_out <= 1'b0;
         err_cnt_out  <= '0;
      end else begin
         sync_err_out <= early_sync || missing_sync;
         if ((early_sync || missing_sync) && (err_cnt_out != '1)) begin
            err_cnt_out <= err_cnt_out + ERR_W'(1);
         end
      end
   end

   assign sel_out    = slot;
   assign locked_out = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Randomised scoreboard bench for tdm_demux_1to4 using a queue-based frame model.
// Directed scenarios come first, then a long random stream with injected sync faults.
module tb_tdm_demux_1to4;

   localparam int DW    = 2;
   localparam int ERR_W = 2;

   logic              clk_in = 1'b0;
   logic              rst_n_in = 1'b0;
   logic [DW-1:0]     d_in = '0;
   logic              valid_in = 1'b0;
   logic              frame_sync_in = 1'b0;
   logic [4*DW-1:0]   y_out;
   logic              y_valid_out;
   logic [1:0]        sel_out;
   logic              locked_out;
   logic              sync_err_out;
   logic [ERR_W-1:0]  err_cnt_out;

   tdm_demux_1to4 #(.DW(DW), .ERR_W(ERR_W)) dut (
      .clk_in        (clk_in),
      .rst_n_in      (rst_n_in),
      .d_in          (d_in),
      .valid_in      (valid_in),
      .frame_sync_in (frame_sync_in),
      .y_out         (y_out),
      .y_valid_out   (y_valid_out),
      .sel_out       (sel_out),
      .locked_out    (locked_out),
      .sync_err_out  (sync_err_out),
      .err_cnt_out   (err_cnt_out)
   );

   always #5 clk_in = ~clk_in;

   int total = 0;
   int bad   = 0;

   // Reference model: alignment flag plus the samples gathered for the frame in progress.
   bit              m_locked = 1'b0;
   logic [DW-1:0]   m_frame[$];
   int              m_err = 0;
   logic [4*DW-1:0] m_last = '0;

   logic [4*DW-1:0] exp_frames[$];
   int              exp_errs[$];

   task automatic checkVal(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic noteErr();
      if (m_err < (1 << ERR_W) - 1) m_err++;
      exp_errs.push_back(m_err);
   endtask

   task automatic modelStep(input bit v, input bit s, input logic [DW-1:0] d);
      if (!v) return;
      if (!m_locked) begin
         if (s) begin
            m_locked = 1'b1;
            m_frame  = {d};
         end
      end else if (s && m_frame.size() != 0) begin
         noteErr();
         m_frame = {d};
      end else if (!s && m_frame.size() == 0) begin
         noteErr();
         m_locked = 1'b0;
      end else begin
         m_frame.push_back(d);
         if (m_frame.size() == 4) begin
            m_last = {m_frame[3], m_frame[2], m_frame[1], m_frame[0]};
            exp_frames.push_back(m_last);
            m_frame.delete();
         end
      end
   endtask

   task automatic checkOutput();
      checkVal("sel", sel_out, m_locked ? m_frame.size() : 0);
      checkVal("locked", locked_out, m_locked);
      checkVal("y_hold", y_out, m_last);
      checkVal("err_cnt", err_cnt_out, m_err);
   endtask

   task automatic applyStimulus(input bit v, input bit s, input logic [DW-1:0] d);
      valid_in      = v;
      frame_sync_in = s;
      d_in          = d;
      @(posedge clk_in);
      modelStep(v, s, d);
      #1;
      checkOutput();
   endtask

   task automatic applyReset();
      valid_in      = 1'b0;
      frame_sync_in = 1'b0;
      rst_n_in      = 1'b0;
      @(posedge clk_in);
      m_locked = 1'b0;
      m_frame.delete();
      m_err  = 0;
      m_last = '0;
      #1;
      rst_n_in = 1'b1;
      checkOutput();
      checkVal("rst_y_valid", y_valid_out, 0);
      checkVal("rst_sync_err", sync_err_out, 0);
   endtask

   task automatic sendFrame(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] c, input logic [DW-1:0] e, input int gap);
      logic [DW-1:0] vals[4];
      vals = '{a, b, c, e};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, i == 0, vals[i]);
         for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, '0);
      end
   endtask

   // Monitor: every strobe from the DUT must match the next queued expectation.
   always @(negedge clk_in) begin
      if (y_valid_out) begin
         if (exp_frames.size() == 0) checkVal("unexpected_y_valid", 1, 0);
         else checkVal("frame", y_out, exp_frames.pop_front());
      end
      if (sync_err_out) begin
         if (exp_errs.size() == 0) checkVal("unexpected_sync_err", 1, 0);
         else checkVal("err_event_cnt", err_cnt_out, exp_errs.pop_front());
      end
   end

   initial begin
      bit v, s, good;
      repeat (2) @(posedge clk_in);
      applyReset();

      $display("[TB] clean stream");
      sendFrame(2'd1, 2'd0, 2'd1, 2'd1, 0);
      checkVal("clean_pulse", y_valid_out, 1);
      checkVal("clean_y", y_out, 8'b01_01_00_01);
      applyStimulus(1'b0, 1'b0, '0);
      checkVal("clean_pulse_once", y_valid_out, 0);

      $display("[TB] gapped stream");
      sendFrame(2'd1, 2'd0, 2'd1, 2'd1, 3);
      checkVal("gapped_y", y_out, 8'b01_01_00_01);

      $display("[TB] early sync");
      applyReset();
      applyStimulus(1'b1, 1'b1, 2'd3);
      applyStimulus(1'b1, 1'b0, 2'd2);
      applyStimulus(1'b1, 1'b1, 2'd1);
      checkVal("early_err_pulse", sync_err_out, 1);
      checkVal("early_err_cnt", err_cnt_out, 1);
      applyStimulus(1'b1, 1'b0, 2'd2);
      applyStimulus(1'b1, 1'b0, 2'd3);
      applyStimulus(1'b1, 1'b0, 2'd0);
      checkVal("early_y", y_out, 8'b00_11_10_01);

      $display("[TB] missing sync");
      applyStimulus(1'b1, 1'b0, 2'd2);
      checkVal("missing_locked", locked_out, 0);
      checkVal("missing_sel", sel_out, 0);
      checkVal("missing_err_pulse", sync_err_out, 1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 2'(i));

      $display("[TB] saturation");
      applyReset();
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 2'(i));
      checkVal("sat_cnt", err_cnt_out, 3);

      $display("[TB] reset mid-frame");
      applyReset();
      applyStimulus(1'b1, 1'b1, 2'd1);
      applyStimulus(1'b1, 1'b0, 2'd2);
      applyReset();
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 2'd3);
      checkVal("post_rst_locked", locked_out, 0);
      sendFrame(2'd2, 2'd3, 2'd0, 2'd1, 1);

      $display("[TB] random stream");
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 499) == 0) begin
            applyReset();
         end else begin
            v    = $urandom_range(0, 99) < 70;
            good = m_locked ? (m_frame.size() == 0) : ($urandom_range(0, 3) == 0);
            s    = ($urandom_range(0, 99) < 4) ? !good : good;
            applyStimulus(v, s, DW'($urandom));
         end
      end

      repeat (3) applyStimulus(1'b0, 1'b0, '0);
      checkVal("frames_left", exp_frames.size(), 0);
      checkVal("errs_left", exp_errs.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
